dqsw_training_seq: RTL and testbench

- Sequences the dynamic delay line and eye monitor of one DQSW270 training IOD lane.
- On request, it reloads the delay line to its static value and steps it tap-by-tap. At each tap it votes on the eye-monitor early/late flags and stops at the first late-to-early transition.
- Sits between the LPDDR3 training state machine and the per-lane IOD delay and eye-monitor controls, all in the FAB_CLK domain.

---
 rtl/dqsw_training_seq.sv | 179 +++++++++++++++++
 tb/tb_dqsw_training_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dqsw_training_seq.sv
// Training sequencer for one DQSW270 IOD lane: reloads the delay line, steps it tap by tap,
// votes on the eye-monitor flags and stops at the first late-to-early transition.
module dqsw_training_seq #(
  parameter int TAP_W         = 8,
  parameter int MAX_TAPS      = 128,
  parameter int SETTLE_CYCLES = 8,
  parameter int VOTES         = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             TRAIN_START,
  input  logic             TRAIN_ABORT,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             TRAIN_BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_FAIL,
  output logic [TAP_W-1:0] TAP_RESULT
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_CLEAR  = 4'd2,
    ST_SETTLE = 4'd3,
    ST_SAMPLE = 4'd4,
    ST_EVAL   = 4'd5,
    ST_MOVE   = 4'd6,
    ST_DONE   = 4'd7,
    ST_FAIL   = 4'd8
  } state_t;

  state_t             state_r;
  logic [TAP_W-1:0]   tap_cnt_r;
  logic [TAP_W-1:0]   tap_result_r;
  logic [SET_W-1:0]   settle_cnt_r;
  logic [3:0]         vote_idx_r;
  logic [3:0]         early_cnt_r;
  logic [3:0]         late_cnt_r;
  logic               prev_valid_r;
  logic               prev_late_r;
  logic               load_r;
  logic               move_r;
  logic               clear_r;
  logic               busy_r;
  logic               done_r;
  logic               fail_r;
  logic               cur_early_s;
  logic               cur_late_s;

  // Majority classification of the current tap; neither set means a tie.
  always_comb begin
    cur_early_s = (early_cnt_r > late_cnt_r);
    cur_late_s  = (late_cnt_r > early_cnt_r);
  end

  // Sequencer state, counters and registered outputs; pulses are raised on entry to their state.
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      state_r      <= ST_IDLE;
      tap_cnt_r    <= {TAP_W{1'b0}};
      tap_result_r <= {TAP_W{1'b0}};
      settle_cnt_r <= {SET_W{1'b0}};
      vote_idx_r   <= 4'd0;
      early_cnt_r  <= 4'd0;
      late_cnt_r   <= 4'd0;
      prev_valid_r <= 1'b0;
      prev_late_r  <= 1'b0;
      load_r       <= 1'b0;
      move_r       <= 1'b0;
      clear_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fail_r       <= 1'b0;
    end else begin
      load_r  <= 1'b0;
      move_r  <= 1'b0;
      clear_r <= 1'b0;
      if (TRAIN_ABORT) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
        done_r  <= 1'b0;
        fail_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (TRAIN_START) begin
              state_r <= ST_LOAD;
              load_r  <= 1'b1;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
              fail_r  <= 1'b0;
            end
          end
          ST_LOAD: begin
            tap_cnt_r    <= {TAP_W{1'b0}};
            prev_valid_r <= 1'b0;
            clear_r      <= 1'b1;
            state_r      <= ST_CLEAR;
          end
          ST_CLEAR: begin
            early_cnt_r  <= 4'd0;
            late_cnt_r   <= 4'd0;
            vote_idx_r   <= 4'd0;
            settle_cnt_r <= {SET_W{1'b0}};
            state_r      <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_cnt_r == SET_W'(SETTLE_CYCLES - 1)) begin
              state_r <= ST_SAMPLE;
            end else begin
              settle_cnt_r <= settle_cnt_r + SET_W'(1);
            end
          end
          ST_SAMPLE: begin
            early_cnt_r <= early_cnt_r + {3'd0, EYE_MONITOR_EARLY};
            late_cnt_r  <= late_cnt_r + {3'd0, EYE_MONITOR_LATE};
            if (vote_idx_r == 4'(VOTES - 1)) begin
              state_r <= ST_EVAL;
            end else begin
              vote_idx_r <= vote_idx_r + 4'd1;
            end
          end
          ST_EVAL: begin
            if (prev_valid_r && prev_late_r && cur_early_s) begin
              tap_result_r <= tap_cnt_r;
              state_r      <= ST_DONE;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
            end else if (DELAY_LINE_OUT_OF_RANGE || (tap_cnt_r == TAP_W'(MAX_TAPS))) begin
              tap_result_r <= tap_cnt_r;
              state_r      <= ST_FAIL;
              busy_r       <= 1'b0;
              fail_r       <= 1'b1;
            end else begin
              // A tied tap leaves the previous classification in place.
              if (cur_early_s || cur_late_s) begin
                prev_late_r  <= cur_late_s;
                prev_valid_r <= 1'b1;
              end
              move_r  <= 1'b1;
              state_r <= ST_MOVE;
            end
          end
          ST_MOVE: begin
            if (tap_cnt_r < TAP_W'(MAX_TAPS)) begin
              tap_cnt_r <= tap_cnt_r + TAP_W'(1);
            end
            clear_r <= 1'b1;
            state_r <= ST_CLEAR;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            fail_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DELAY_LINE_LOAD         = load_r;
  assign DELAY_LINE_MOVE         = move_r;
  assign DELAY_LINE_DIRECTION    = busy_r;
  assign EYE_MONITOR_CLEAR_FLAGS = clear_r;
  assign TRAIN_BUSY              = busy_r;
  assign TRAIN_DONE              = done_r;
  assign TRAIN_FAIL              = fail_r;
  assign TAP_RESULT              = tap_result_r;

endmodule

// File: tb/tb_dqsw_training_seq.sv
// Randomized bench for dqsw_training_seq: per-tap eye vote patterns drive the lane and a
// tap-level model predicts where the late-to-early transition (or failure) lands.
module tb_dqsw_training_seq;

  localparam int MAX_TAPS = 128;
  localparam int SETTLE   = 8;
  localparam int VOTES    = 4;
  localparam int TAP_LEN  = 1 + SETTLE + VOTES + 1 + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       train_start, train_abort;
  logic       eye_early, eye_late, oor;
  logic       dl_load, dl_move, dl_dir, eye_clear;
  logic       busy, done, fail;
  logic [7:0] tap_result;

  dqsw_training_seq #(.TAP_W(8), .MAX_TAPS(MAX_TAPS), .SETTLE_CYCLES(SETTLE), .VOTES(VOTES)) dut (
    .FAB_CLK(clk), .RESET(rst), .TRAIN_START(train_start), .TRAIN_ABORT(train_abort),
    .EYE_MONITOR_EARLY(eye_early), .EYE_MONITOR_LATE(eye_late),
    .DELAY_LINE_OUT_OF_RANGE(oor), .DELAY_LINE_LOAD(dl_load), .DELAY_LINE_MOVE(dl_move),
    .DELAY_LINE_DIRECTION(dl_dir), .EYE_MONITOR_CLEAR_FLAGS(eye_clear),
    .TRAIN_BUSY(busy), .TRAIN_DONE(done), .TRAIN_FAIL(fail), .TAP_RESULT(tap_result)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Per-tap vote patterns (bit v = flag value during the v-th sample cycle) and the OOR tap.
  logic [3:0] ev [0:MAX_TAPS];
  logic [3:0] lv [0:MAX_TAPS];
  int oor_tap;
  int cur_abort_tap;
  bit cur_inject;

  // Observation state maintained by step().
  int k, tap, loads, moves, overlap, dir_bad, spacing_bad, cyc, last_mv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Tap-level reference: walk taps, classify by vote majority, find the L->E edge.
  function automatic void model(output int res, output bit is_fail);
    int prev;
    int e, l, cur;
    prev = 0;
    res = MAX_TAPS;
    is_fail = 1'b1;
    for (int t = 0; t <= MAX_TAPS; t++) begin
      e = $countones(ev[t]);
      l = $countones(lv[t]);
      cur = (e > l) ? 2 : ((l > e) ? 1 : 0);
      if (prev == 1 && cur == 2) begin
        res = t; is_fail = 1'b0; return;
      end
      if ((oor_tap >= 0 && t >= oor_tap) || t == MAX_TAPS) begin
        res = t; is_fail = 1'b1; return;
      end
      if (cur != 0) prev = cur;
    end
  endfunction

  function automatic void fill_step(input int first_early);
    for (int t = 0; t <= MAX_TAPS; t++) begin
      ev[t] = (t >= first_early) ? 4'hF : 4'h0;
      lv[t] = (t >= first_early) ? 4'h0 : 4'hF;
    end
  endfunction

  function automatic void fill_random(input int first_early);
    logic [3:0] hi, lo;
    for (int t = 0; t <= MAX_TAPS; t++) begin
      hi = 4'($urandom) | 4'($urandom);
      lo = 4'($urandom) & 4'($urandom);
      ev[t] = (t >= first_early) ? hi : lo;
      lv[t] = (t >= first_early) ? lo : hi;
    end
  endfunction

  // One cycle: observe at the falling edge, then drive inputs for this cycle.
  task automatic step();
    int v, idx;
    @(negedge clk);
    if ((int'(dl_load) + int'(dl_move) + int'(eye_clear)) > 1) overlap++;
    if (dl_dir !== busy) dir_bad++;
    if (dl_move === 1'b1) begin
      if (last_mv >= 0 && (cyc - last_mv) != TAP_LEN) spacing_bad++;
      last_mv = cyc;
    end
    if (dl_load === 1'b1) begin
      k = 0; tap = 0; loads++;
    end else if (dl_move === 1'b1) begin
      k = 0; tap++; moves++;
    end else begin
      k++;
    end
    idx = (tap > MAX_TAPS) ? MAX_TAPS : tap;
    v = k - (1 + 1 + SETTLE);
    if (v >= 0 && v < VOTES) begin
      eye_early = ev[idx][v];
      eye_late  = lv[idx][v];
    end else begin
      eye_early = 1'($urandom);
      eye_late  = 1'($urandom);
    end
    if (k == 1 + 1 + SETTLE + VOTES) oor = (oor_tap >= 0 && tap >= oor_tap);
    else oor = 1'($urandom);
    train_start = cur_inject && tap == 2 && k == 5;
    train_abort = cur_abort_tap >= 0 && tap == cur_abort_tap && k == 1 + 1 + SETTLE + 1;
    cyc++;
  endtask

  task automatic run_train(input string name);
    int exp_res, snap_mv, snap_ld;
    bit exp_fail, finished;
    logic [7:0] res_before;
    model(exp_res, exp_fail);
    res_before = tap_result;
    k = 1000; tap = 0; loads = 0; moves = 0; overlap = 0; dir_bad = 0;
    spacing_bad = 0; cyc = 0; last_mv = -1; finished = 1'b0;
    train_start = 1'b1;
    for (int c = 0; c < 2500 && !finished; c++) begin
      step();
      if (c == 0) begin
        chk({name, ":load_next"}, dl_load, 1);
        chk({name, ":flags_drop"}, {done, fail}, 0);
      end
      if (train_abort) begin
        step();
        chk({name, ":abort_idle"}, {busy, done, fail, dl_load, dl_move, eye_clear}, 0);
        chk({name, ":abort_moves"}, moves, cur_abort_tap);
        snap_mv = moves; snap_ld = loads;
        repeat (30) step();
        chk({name, ":post_abort_pulses"}, moves + loads, snap_mv + snap_ld);
        chk({name, ":abort_result_kept"}, tap_result, res_before);
        finished = 1'b1;
      end else if (done === 1'b1 || fail === 1'b1) begin
        chk({name, ":done"}, done, !exp_fail);
        chk({name, ":fail"}, fail, exp_fail);
        chk({name, ":tap_result"}, tap_result, exp_res);
        chk({name, ":loads"}, loads, 1);
        chk({name, ":moves"}, moves, exp_res);
        chk({name, ":busy_end"}, busy, 0);
        chk({name, ":protocol"}, overlap + dir_bad + spacing_bad, 0);
        snap_mv = moves; snap_ld = loads;
        repeat (5) step();
        chk({name, ":quiet_after"}, moves + loads, snap_mv + snap_ld);
        finished = 1'b1;
      end
    end
    if (!finished) chk({name, ":timeout"}, 0, 1);
    cur_abort_tap = -1;
    cur_inject = 1'b0;
  endtask

  initial begin
    int first, n;
    rst = 1'b1; train_start = 1'b0; train_abort = 1'b0;
    eye_early = 1'b0; eye_late = 1'b0; oor = 1'b0;
    oor_tap = -1; cur_abort_tap = -1; cur_inject = 1'b0;
    #1;
    chk("reset_outputs", {dl_load, dl_move, dl_dir, eye_clear, busy, done, fail}, 0);
    chk("reset_tap_result", tap_result, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    fill_step(37);
    run_train("late_to_37");

    fill_step(MAX_TAPS + 10);
    run_train("always_late");

    fill_step(11);
    ev[10] = 4'b0101; lv[10] = 4'b1010;
    run_train("tie_at_10");

    fill_step(MAX_TAPS + 10);
    oor_tap = 20;
    run_train("oor_at_20");
    oor_tap = -1;

    fill_step(37);
    cur_abort_tap = 5;
    run_train("abort_tap5");
    fill_step(12);
    run_train("restart");

    for (int i = 0; i < 6; i++) begin
      first = $urandom_range(1, 40);
      fill_random(first);
      oor_tap = ($urandom_range(0, 9) < 3) ? $urandom_range(0, 45) : -1;
      cur_inject = 1'b1;
      run_train("random");
    end
    oor_tap = -1;

    fill_step(37);
    run_train("pre_reset");
    fill_step(37);
    k = 1000; moves = 0; loads = 0; tap = 0; last_mv = -1;
    train_start = 1'b1;
    n = 0;
    step();
    while (!(dl_move === 1'b1 && moves == 3) && n < 200) begin
      step();
      n++;
    end
    chk("reached_move", dl_move, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {dl_load, dl_move, dl_dir, eye_clear, busy, done, fail}, 0);
    chk("rst_mid_tap_result", tap_result, 0);
    @(negedge clk);
    rst = 1'b0;
    moves = 0; loads = 0;
    repeat (20) step();
    chk("rst_quiet", moves + loads + int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
